// File: rtl/mux1hot8_rr_arbiter.sv
// Round-robin arbiter for eight requesters feeding one W-bit valid/ready output register.
// Optional multi-beat transfer locking is enabled by defining MUX1HOT_ARB_LOCK_EN.
module mux1hot8_rr_arbiter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_valid,
  input  logic [7:0]   in_last,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [W-1:0] in3,
  input  logic [W-1:0] in4,
  input  logic [W-1:0] in5,
  input  logic [W-1:0] in6,
  input  logic [W-1:0] in7,
  output logic [7:0]   in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [7:0]   out_grant
);

  logic [2:0]   ptr;
  logic [7:0]   req;
  logic [7:0]   sel;
  logic [2:0]   win_idx;
  logic         win_any;
  logic         slot_free;
  logic         accept;
  logic [W-1:0] mux_data;
  logic [W-1:0] in_arr [8];

  assign in_arr[0] = in0;
  assign in_arr[1] = in1;
  assign in_arr[2] = in2;
  assign in_arr[3] = in3;
  assign in_arr[4] = in4;
  assign in_arr[5] = in5;
  assign in_arr[6] = in6;
  assign in_arr[7] = in7;

`ifdef MUX1HOT_ARB_LOCK_EN
  logic       lock;
  logic [2:0] lock_id;

  // While locked only the owner may win, even if it is idle this cycle.
  assign req = lock ? (in_valid & (8'd1 << lock_id)) : in_valid;
`else
  logic unused_last;

  assign unused_last = ^in_last;
  assign req         = in_valid;
`endif

  // First requester at or after ptr, wrapping from 7 back to 0.
  always_comb begin
    logic [2:0] idx;
    win_any = 1'b0;
    win_idx = ptr;
    idx     = ptr;
    for (int k = 0; k < 8; k++) begin
      idx = ptr + 3'(k);
      if (!win_any && req[idx]) begin
        win_any = 1'b1;
        win_idx = idx;
      end
    end
    sel = win_any ? (8'd1 << win_idx) : 8'd0;
  end

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < 8; i++) begin
      if (sel[i]) mux_data = mux_data | in_arr[i];
    end
  end

  // Handshake: a beat moves on in_valid[i] && in_ready[i]; the output beat moves on
  // out_valid && out_ready. in_ready is held low while reset is asserted.
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (rst_n && slot_free) ? sel : 8'd0;
  assign accept    = |in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_grant <= 8'd0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_grant <= sel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_grant <= 8'd0;
    end
  end

`ifdef MUX1HOT_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= 3'd0;
      lock    <= 1'b0;
      lock_id <= 3'd0;
    end else if (accept) begin
      if (in_last[win_idx]) begin
        lock <= 1'b0;
        ptr  <= win_idx + 3'd1;
      end else begin
        lock    <= 1'b1;
        lock_id <= win_idx;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 3'd0;
    end else if (accept) begin
      ptr <= win_idx + 3'd1;
    end
  end
`endif

endmodule

// File: doc/mux1hot8_rr_arbiter.md
# mux1hot8_rr_arbiter

Round-robin arbiter and output register that shares one W-bit channel among eight requesters. It generates the one-hot select for an internal 8-input one-hot mux and returns a per-requester accept. The winning beat is captured into a valid/ready output register. The block sits in front of any single-consumer resource fed by up to eight producers, and sustains one beat per cycle.

## Interface
Parameters:
- W, default 8: data width of every input and of the output.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- in_valid, input, 8: bit i set means requester i offers a beat on in<i>.
- in_last, input, 8: bit i set means the offered beat from requester i ends its transfer. Used only with MUX1HOT_ARB_LOCK_EN; ignored otherwise.
- in0..in7, input, W each: requester data.
- in_ready, output, 8: one-hot or zero. Bit i set means the beat from requester i is accepted this cycle.
- out_valid, output, 1: the output register holds a beat.
- out_ready, input, 1: the consumer takes the beat when out_valid && out_ready.
- out_data, output, W: registered selected data.
- out_grant, output, 8: one-hot source id of out_data; zero when out_valid = 0.

## Operation
- Slot free condition: `slot_free = !out_valid || out_ready`.
- Arbitration:
  - Runs every cycle. The winner is the first set bit of in_valid, scanning from `ptr` upward with wrap from 7 to 0.
  - Combinational `sel` is one-hot of the winner, or zero if there are no requests.
  - `in_ready = slot_free ? sel : 8'b0`.
- Accepting a beat (in_ready[g] set):
  - At the next edge: out_data <= in<g>, out_grant <= onehot(g), out_valid <= 1, ptr <= (g+1) mod 8.
- Draining: if out_valid && out_ready and nothing is accepted, then at the next edge out_valid <= 0 and out_grant <= 0. out_data holds its last value.
- Stall: while out_valid && !out_ready, the following hold stable and ptr is unchanged:
  - in_ready is zero.
  - out_data and out_grant do not change.
- Producer rule: a requester holds in_valid and its data until in_ready is seen. The arbiter does not check this. A request withdrawn before acceptance simply drops out of the scan.
- Fairness: with all eight requesting continuously and out_ready = 1, grants cycle 0,1,...,7,0 with no repeats. Each requester waits at most 7 grants.
- Reset values:
  - out_valid = 0, out_data = 0, out_grant = 0.
  - ptr = 0, so requester 0 has first priority.
  - Lock cleared.
  - in_ready = 0 while rst_n is low.
- Reset mid-operation: asserting rst_n immediately clears all state, including a held beat and any lock. A beat held at reset is lost.

## Timing
- Latency: a beat accepted in cycle t appears with out_valid = 1 in cycle t+1.
- Throughput: one beat per cycle while out_ready = 1.
- in_ready is combinational from in_valid, ptr, lock state, out_valid and out_ready. There is no register between them.
- out_valid, out_data and out_grant are registered outputs.
- A beat is accepted in the same cycle the held beat drains, so there is no bubble on back-to-back traffic.

## Configuration
- Macro: MUX1HOT_ARB_LOCK_EN.
- When defined, multi-beat transfers are locked:
  - When requester g is accepted with in_last[g] = 0, the arbiter sets `lock = 1` and `lock_id = g`.
  - While locked, `sel` considers only in_valid[lock_id]. All other requesters see in_ready = 0, even if lock_id is idle, which produces a bubble.
  - Acceptance with in_last[lock_id] = 1 clears the lock.
  - ptr advances only when the lock releases, or when a beat is accepted with last = 1 while unlocked.
- When not defined:
  - No lock register exists and in_last is unused.
  - Every beat is arbitrated independently and ptr advances on every grant.

## Test plan
- Reset and idle:
  - Stimulus: hold rst_n = 0, drive in_valid = 8'hFF, then release reset.
  - Required during reset: out_valid = 0, out_grant = 0, in_ready = 0.
  - Required first cycle after release: in_ready = 8'h01.
- Full round-robin:
  - Stimulus: in_valid = 8'hFF, out_ready = 1, in<i> = 8'h10+i, for 16 cycles.
  - Required: out_data sequence 10,11,...,17,10,...,17; out_grant tracks it one-hot.
- Sparse wrap:
  - Stimulus: in_valid = 8'b1000_0010, with ptr = 2 after a grant to 1.
  - Required: next grant is 7, then ptr = 0, then grant is 1.
- Backpressure:
  - Stimulus: out_ready = 0 for 4 cycles while out_valid = 1 and in_valid = 8'h0F.
  - Required: out_data and out_grant stable, in_ready = 0. On out_ready = 1, the next beat is accepted in the same cycle.
- Async reset mid-stall:
  - Stimulus: pulse rst_n low between clock edges while a beat is held.
  - Required: out_valid drops to 0 immediately, without waiting for a clock edge, and ptr returns to 0.
- Lock (only with MUX1HOT_ARB_LOCK_EN):
  - Stimulus: requester 3 sends 3 beats with last = 0,0,1 while requester 4 requests continuously.
  - Required: grants 3,3,3, then 4. If requester 3 drops in_valid mid-transfer, in_ready = 0 for all and out_valid falls after the drain.
